// File: rtl/mips_pipe_pkg.sv
// Shared pipeline-control encodings for the MIPS hazard unit: forwarding selects,
// MemtoReg load code, hazard FSM states and the stall/flush control bundle.
package mips_pipe_pkg;

   localparam int unsigned REG_W = 5;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   localparam logic [1:0] MEMTOREG_LOAD = 2'b01;

   localparam logic [1:0] RUN     = 2'd0;
   localparam logic [1:0] MEMWAIT = 2'd1;
   localparam logic [1:0] TIMEOUT = 2'd2;

   // Stall (active-low write enables) and flush controls for the pipeline registers
   typedef struct packed {
      logic we_n_f;
      logic we_n_d;
      logic we_n_e;
      logic we_n_m;
      logic we_n_w;
      logic clr_d;
      logic clr_e;
   } haz_ctl_t;

   localparam haz_ctl_t CTL_FREEZE = '{we_n_f: 1'b1, we_n_d: 1'b1, we_n_e: 1'b1,
                                       we_n_m: 1'b1, we_n_w: 1'b1,
                                       clr_d: 1'b0, clr_e: 1'b0};

   // M-stage result wins over W-stage; $0 is never forwarded
   function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                          input logic             rw_m,
                                          input logic [REG_W-1:0] wr_m,
                                          input logic             rw_w,
                                          input logic [REG_W-1:0] wr_w);
      logic [1:0] sel;
      sel = FWD_RF;
      if (rw_m && (wr_m != REG_W'(0)) && (wr_m == src)) begin
         sel = FWD_M;
      end else if (rw_w && (wr_w != REG_W'(0)) && (wr_w == src)) begin
         sel = FWD_W;
      end
      return sel;
   endfunction

endpackage

// File: rtl/mips_hazard_ctrl_if.sv
// Pipeline-side bundle seen by the hazard controller: stage register numbers and
// control bits in, stall/flush/forward controls out.
interface mips_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic [4:0]       i_RsD;
   logic [4:0]       i_RtD;
   logic [4:0]       i_RsE;
   logic [4:0]       i_RtE;
   logic [1:0]       i_MemtoRegE;
   logic             i_RegWriteE;
   logic [4:0]       i_WriteRegM;
   logic             i_RegWriteM;
   logic [4:0]       i_WriteRegW;
   logic             i_RegWriteW;
   logic             i_PCSrcD;
   logic             i_DmemReq;
   logic             i_DmemRdy;

   logic             o_WE_n_F;
   logic             o_WE_n_D;
   logic             o_WE_n_E;
   logic             o_WE_n_M;
   logic             o_WE_n_W;
   logic             o_CLR_D;
   logic             o_CLR_E;
   logic [1:0]       o_FwdAE;
   logic [1:0]       o_FwdBE;
   logic             o_MemTimeout;
   logic [CNT_W-1:0] o_StallCycles;

   // Hazard controller side
   modport master (
      input  i_RsD, i_RtD, i_RsE, i_RtE, i_MemtoRegE, i_RegWriteE,
             i_WriteRegM, i_RegWriteM, i_WriteRegW, i_RegWriteW,
             i_PCSrcD, i_DmemReq, i_DmemRdy,
      output o_WE_n_F, o_WE_n_D, o_WE_n_E, o_WE_n_M, o_WE_n_W,
             o_CLR_D, o_CLR_E, o_FwdAE, o_FwdBE, o_MemTimeout, o_StallCycles
   );

   // Pipeline datapath side
   modport slave (
      output i_RsD, i_RtD, i_RsE, i_RtE, i_MemtoRegE, i_RegWriteE,
             i_WriteRegM, i_RegWriteM, i_WriteRegW, i_RegWriteW,
             i_PCSrcD, i_DmemReq, i_DmemRdy,
      input  o_WE_n_F, o_WE_n_D, o_WE_n_E, o_WE_n_M, o_WE_n_W,
             o_CLR_D, o_CLR_E, o_FwdAE, o_FwdBE, o_MemTimeout, o_StallCycles
   );

endinterface

// File: rtl/mips_fwd_unit.sv
// EX-stage operand forwarding selects; purely combinational register-number compare.
module mips_fwd_unit
   import mips_pipe_pkg::*;
(
   input  logic [REG_W-1:0] i_RsE,
   input  logic [REG_W-1:0] i_RtE,
   input  logic [REG_W-1:0] i_WriteRegM,
   input  logic             i_RegWriteM,
   input  logic [REG_W-1:0] i_WriteRegW,
   input  logic             i_RegWriteW,
   output logic [1:0]       o_FwdAE,
   output logic [1:0]       o_FwdBE
);

   always_comb begin
      o_FwdAE = fwd_sel(i_RsE, i_RegWriteM, i_WriteRegM, i_RegWriteW, i_WriteRegW);
      o_FwdBE = fwd_sel(i_RtE, i_RegWriteM, i_WriteRegM, i_RegWriteW, i_WriteRegW);
   end

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, data-memory wait freeze
// with watchdog. Optional stall-cycle counter built when HAZ_PERF_EN is defined.
module mips_hazard_ctrl
   import mips_pipe_pkg::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 16,
   parameter int unsigned CNT_W        = 32
) (
   input  logic                   i_Clk,
   input  logic                   Reset,
   mips_hazard_ctrl_if.master     bus
);

   localparam int unsigned      WAIT_W   = $clog2(MEM_WAIT_MAX + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_WAIT_MAX);

   logic [1:0]        state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [WAIT_W-1:0] wait_inc;
   logic              timeout_q, timeout_d;
   logic              lwstall;
   logic              memwait;
   haz_ctl_t          ctl;

   mips_fwd_unit u_fwd (
      .i_RsE       (bus.i_RsE),
      .i_RtE       (bus.i_RtE),
      .i_WriteRegM (bus.i_WriteRegM),
      .i_RegWriteM (bus.i_RegWriteM),
      .i_WriteRegW (bus.i_WriteRegW),
      .i_RegWriteW (bus.i_RegWriteW),
      .o_FwdAE     (bus.o_FwdAE),
      .o_FwdBE     (bus.o_FwdBE)
   );

   always_comb begin
      lwstall = bus.i_RegWriteE && (bus.i_MemtoRegE == MEMTOREG_LOAD) &&
                (bus.i_RtE != REG_W'(0)) &&
                ((bus.i_RtE == bus.i_RsD) || (bus.i_RtE == bus.i_RtD));
      memwait = bus.i_DmemReq && !bus.i_DmemRdy;
      wait_inc = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
   end

   // Next state and controls; memory freeze outranks load-use, which outranks branch flush
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
      ctl        = '0;
      case (state_q)
         RUN: begin
            if (memwait) begin
               ctl        = CTL_FREEZE;
               wait_cnt_d = WAIT_W'(1);
               if (WAIT_LIM <= WAIT_W'(1)) begin
                  state_d   = TIMEOUT;
                  timeout_d = 1'b1;
               end else begin
                  state_d = MEMWAIT;
               end
            end else if (lwstall) begin
               ctl.we_n_f = 1'b1;
               ctl.we_n_d = 1'b1;
               ctl.clr_e  = 1'b1;
            end else if (bus.i_PCSrcD) begin
               ctl.clr_d = 1'b1;
            end
         end
         MEMWAIT: begin
            ctl = CTL_FREEZE;
            // A dropped request ends the wait just like ready
            if (bus.i_DmemRdy || !bus.i_DmemReq) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else begin
               wait_cnt_d = wait_inc;
               if (wait_inc >= WAIT_LIM) begin
                  state_d   = TIMEOUT;
                  timeout_d = 1'b1;
               end
            end
         end
         TIMEOUT: begin
            ctl       = CTL_FREEZE;
            timeout_d = 1'b1;
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge i_Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign bus.o_WE_n_F     = ctl.we_n_f;
   assign bus.o_WE_n_D     = ctl.we_n_d;
   assign bus.o_WE_n_E     = ctl.we_n_e;
   assign bus.o_WE_n_M     = ctl.we_n_m;
   assign bus.o_WE_n_W     = ctl.we_n_w;
   assign bus.o_CLR_D      = ctl.clr_d;
   assign bus.o_CLR_E      = ctl.clr_e;
   assign bus.o_MemTimeout = timeout_q;

`ifdef HAZ_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of cycles with the PC held
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (ctl.we_n_f && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_Clk or negedge Reset) begin
      if (!Reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.o_StallCycles = stall_cnt_q;
`else
   assign bus.o_StallCycles = '0;
`endif

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Directed bench for mips_hazard_ctrl (MEM_WAIT_MAX=4); stall-count expectations follow HAZ_PERF_EN.
module tb_mips_hazard_ctrl;
   import mips_pipe_pkg::*;

`ifdef HAZ_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // {WE_n_F, WE_n_D, WE_n_E, WE_n_M, WE_n_W, CLR_D, CLR_E}
   localparam logic [6:0] C_IDLE = 7'b0000000;
   localparam logic [6:0] C_LW   = 7'b1100001;
   localparam logic [6:0] C_BR   = 7'b0000010;
   localparam logic [6:0] C_FRZ  = 7'b1111100;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   mips_hazard_ctrl_if #(.CNT_W(32)) bus ();

   mips_hazard_ctrl #(.MEM_WAIT_MAX(4), .CNT_W(32)) dut (
      .i_Clk (clk),
      .Reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish before 200000");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [6:0] ctl_obs();
      return {bus.o_WE_n_F, bus.o_WE_n_D, bus.o_WE_n_E, bus.o_WE_n_M, bus.o_WE_n_W,
              bus.o_CLR_D, bus.o_CLR_E};
   endfunction

   task automatic chk_ctl(input string tag, input logic [6:0] exp);
      #1;
      check_eq(tag, 32'(ctl_obs()), 32'(exp));
   endtask

   task automatic chk_fwd(input string tag, input logic [1:0] exp_a, input logic [1:0] exp_b);
      #1;
      check_eq({tag, "_A"}, 32'(bus.o_FwdAE), 32'(exp_a));
      check_eq({tag, "_B"}, 32'(bus.o_FwdBE), 32'(exp_b));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      bus.i_RsD = 5'd0;  bus.i_RtD = 5'd0;  bus.i_RsE = 5'd0;  bus.i_RtE = 5'd0;
      bus.i_MemtoRegE = 2'b00; bus.i_RegWriteE = 1'b0;
      bus.i_WriteRegM = 5'd0; bus.i_RegWriteM = 1'b0;
      bus.i_WriteRegW = 5'd0; bus.i_RegWriteW = 1'b0;
      bus.i_PCSrcD = 1'b0; bus.i_DmemReq = 1'b0; bus.i_DmemRdy = 1'b0;
   endtask

   task automatic set_load(input logic [4:0] rt_e, input logic [4:0] rs_d, input logic [4:0] rt_d);
      bus.i_RegWriteE = 1'b1; bus.i_MemtoRegE = MEMTOREG_LOAD;
      bus.i_RtE = rt_e; bus.i_RsD = rs_d; bus.i_RtD = rt_d;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      set_idle();
      #2;
      check_eq("rst_ctl", 32'(ctl_obs()), 32'(C_IDLE));
      check_eq("rst_timeout", 32'(bus.o_MemTimeout), 32'd0);
      check_eq("rst_stall", bus.o_StallCycles, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk_ctl("run_idle", C_IDLE);

      // Forwarding
      bus.i_RegWriteM = 1'b1; bus.i_WriteRegM = 5'd5;
      bus.i_RegWriteW = 1'b1; bus.i_WriteRegW = 5'd5; bus.i_RsE = 5'd5;
      chk_fwd("fwd_m_prio", FWD_M, FWD_RF);
      bus.i_WriteRegM = 5'd0;
      chk_fwd("fwd_w", FWD_W, FWD_RF);
      bus.i_RtE = 5'd5;
      chk_fwd("fwd_w_both", FWD_W, FWD_W);
      bus.i_WriteRegM = 5'd5; bus.i_RsE = 5'd7;
      chk_fwd("fwd_b_m", FWD_RF, FWD_M);
      bus.i_RegWriteM = 1'b0; bus.i_RegWriteW = 1'b0;
      chk_fwd("fwd_no_rw", FWD_RF, FWD_RF);
      bus.i_RegWriteM = 1'b1; bus.i_WriteRegM = 5'd0;
      bus.i_RegWriteW = 1'b1; bus.i_WriteRegW = 5'd0;
      bus.i_RsE = 5'd0; bus.i_RtE = 5'd0;
      chk_fwd("fwd_zero", FWD_RF, FWD_RF);
      set_idle();

      // Load-use variants and branch flush (combinational, no clock edges)
      set_load(5'd9, 5'd1, 5'd9);
      chk_ctl("lw_rtd", C_LW);
      set_load(5'd0, 5'd0, 5'd0);
      chk_ctl("lw_r0", C_IDLE);
      set_load(5'd9, 5'd9, 5'd2);
      bus.i_MemtoRegE = 2'b00;
      chk_ctl("lw_notload", C_IDLE);
      bus.i_MemtoRegE = MEMTOREG_LOAD; bus.i_RegWriteE = 1'b0;
      chk_ctl("lw_norw", C_IDLE);
      set_idle();
      bus.i_PCSrcD = 1'b1;
      chk_ctl("br_flush", C_BR);
      set_load(5'd8, 5'd8, 5'd0);
      chk_ctl("br_lw", C_LW);
      set_idle();

      // Load-use: one stall cycle then release
      set_load(5'd8, 5'd8, 5'd0);
      chk_ctl("lw_stall", C_LW);
      tick();
      set_idle();
      chk_ctl("lw_release", C_IDLE);

      // Memory wait: three not-ready cycles, then ready
      bus.i_DmemReq = 1'b1; bus.i_DmemRdy = 1'b0;
      chk_ctl("mw_c0", C_FRZ);
      tick();
      bus.i_PCSrcD = 1'b1; set_load(5'd8, 5'd8, 5'd0);
      chk_ctl("mw_c1_override", C_FRZ);
      tick();
      set_idle(); bus.i_DmemReq = 1'b1;
      chk_ctl("mw_c2", C_FRZ);
      tick();
      bus.i_DmemRdy = 1'b1;
      chk_ctl("mw_c3_rdy", C_FRZ);
      tick();
      set_idle();
      chk_ctl("mw_release", C_IDLE);
      check_eq("mw_no_timeout", 32'(bus.o_MemTimeout), 32'd0);
      check_eq("stall_5", bus.o_StallCycles, PERF ? 32'd5 : 32'd0);

      // Dropping the request mid-wait ends the wait
      bus.i_DmemReq = 1'b1;
      tick();
      bus.i_DmemReq = 1'b0;
      chk_ctl("drop_frozen", C_FRZ);
      tick();
      chk_ctl("drop_release", C_IDLE);
      check_eq("stall_7", bus.o_StallCycles, PERF ? 32'd7 : 32'd0);

      // Watchdog: four consecutive not-ready cycles
      bus.i_DmemReq = 1'b1; bus.i_DmemRdy = 1'b0;
      tick();
      tick();
      tick();
      check_eq("wd_before", 32'(bus.o_MemTimeout), 32'd0);
      tick();
      check_eq("wd_fired", 32'(bus.o_MemTimeout), 32'd1);
      bus.i_DmemRdy = 1'b1; bus.i_DmemReq = 1'b0;
      chk_ctl("wd_frozen", C_FRZ);
      tick();
      tick();
      chk_ctl("wd_still_frozen", C_FRZ);
      check_eq("wd_sticky", 32'(bus.o_MemTimeout), 32'd1);
      check_eq("stall_13", bus.o_StallCycles, PERF ? 32'd13 : 32'd0);

      // Asynchronous reset clears everything mid-cycle
      set_idle();
      rst_n = 1'b0;
      #1;
      check_eq("rst2_timeout", 32'(bus.o_MemTimeout), 32'd0);
      check_eq("rst2_stall", bus.o_StallCycles, 32'd0);
      chk_ctl("rst2_ctl", C_IDLE);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      bus.i_PCSrcD = 1'b1;
      chk_ctl("post_rst_run", C_BR);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
